// File: rtl/ay_bus_sequencer.sv
// ay_bus_sequencer
//   Owns the write side (BDIR/BC/DI) of one ay8910 and shares it between the
//   CPU port decoder and a host/OSD register writer. Tracks the AY address
//   latch, keeps a shadow of the CPU-selected register and restores the latch
//   after host/init traffic so CPU reads always see the CPU's register.
//   After reset an optional init sequence silences the chip (R0..R13).
//
// Ports
//   CLK         system clock (same as the ay8910)
//   RESET_N     synchronous active-low reset
//   CPU_REQ     one-cycle CPU port write strobe
//   CPU_SEL     1 = address port, 0 = data port
//   CPU_DI      CPU write data
//   HOST_VALID  host request, held with HOST_REG/HOST_DATA until HOST_ACK
//   HOST_REG    host target register
//   HOST_DATA   host write data
//   HOST_ACK    pulse in the cycle the host data phase is on the bus
//   INIT_DONE   high once init has completed
//   AY_BDIR, AY_BC, AY_DI   registered ay8910 write bus
module ay_bus_sequencer #(
    parameter bit         INIT_EN    = 1'b1,
    parameter logic [7:0] INIT_MIXER = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CPU_REQ,
    input  logic       CPU_SEL,
    input  logic [7:0] CPU_DI,
    input  logic       HOST_VALID,
    input  logic [3:0] HOST_REG,
    input  logic [7:0] HOST_DATA,
    output logic       HOST_ACK,
    output logic       INIT_DONE,
    output logic       AY_BDIR,
    output logic       AY_BC,
    output logic [7:0] AY_DI
);

    localparam logic [2:0] S_INIT  = 3'd0;  // writing R0..R13
    localparam logic [2:0] S_IRST  = 3'd1;  // init restore of the shadow
    localparam logic [2:0] S_IDONE = 3'd2;  // raise INIT_DONE
    localparam logic [2:0] S_IDLE  = 3'd3;
    localparam logic [2:0] S_HOP   = 3'd4;  // host address/data
    localparam logic [2:0] S_HDONE = 3'd5;  // idle cycle, re-sample HOST_VALID
    localparam logic [2:0] S_HRST  = 3'd6;  // host restore of the shadow

    logic [2:0] state, nx_state;
    logic [3:0] init_idx, nx_idx;
    logic [3:0] shadow, nx_shadow;
    logic [3:0] ay_addr, nx_addr;
    logic       ay_avalid, nx_avalid;
    logic       cpu_pend, nx_pend;
    logic [7:0] cpu_data, nx_pdata;
    logic       nx_ack, nx_done;
    logic       nx_bdir, nx_bc;
    logic [7:0] nx_di;

    logic       do_addr, do_data;
    logic [3:0] a_reg;
    logic [7:0] d_val;
    logic       in_init;
    logic       hit_shadow, hit_idx, hit_host;

    assign hit_shadow = ay_avalid && (ay_addr == shadow);
    assign hit_idx    = ay_avalid && (ay_addr == init_idx);
    assign hit_host   = ay_avalid && (ay_addr == HOST_REG);
    assign in_init    = (state == S_INIT) || (state == S_IRST);

    // Every edge picks the next bus cycle: a CPU data phase still owed wins,
    // then a fresh CPU strobe, then the host/init FSM. The FSM only advances
    // when it actually owns the cycle, so preempted work simply resumes and
    // re-checks the tracked address.
    always_comb begin
        nx_state  = state;
        nx_idx    = init_idx;
        nx_shadow = shadow;
        nx_addr   = ay_addr;
        nx_avalid = ay_avalid;
        nx_pend   = cpu_pend;
        nx_pdata  = cpu_data;
        nx_ack    = 1'b0;
        nx_done   = INIT_DONE;
        nx_bdir   = 1'b0;
        nx_bc     = 1'b0;
        nx_di     = '0;
        do_addr   = 1'b0;
        do_data   = 1'b0;
        a_reg     = '0;
        d_val     = '0;

        if (CPU_REQ && CPU_SEL)
            nx_shadow = CPU_DI[3:0];

        // Completion flag is set regardless of who owns this bus cycle.
        if (state == S_IDONE) begin
            nx_done  = 1'b1;
            nx_state = S_IDLE;
        end

        if (cpu_pend) begin
            do_data = 1'b1;
            d_val   = cpu_data;
            nx_pend = 1'b0;
        end else if (CPU_REQ && !in_init) begin
            if (CPU_SEL) begin
                do_addr = 1'b1;
                a_reg   = CPU_DI[3:0];
            end else if (hit_shadow) begin
                do_data = 1'b1;
                d_val   = CPU_DI;
            end else begin
                do_addr  = 1'b1;
                a_reg    = shadow;
                nx_pend  = 1'b1;
                nx_pdata = CPU_DI;
            end
        end else begin
            case (state)
                S_INIT: begin
                    if (hit_idx) begin
                        do_data = 1'b1;
                        d_val   = (init_idx == 4'd7) ? INIT_MIXER : 8'h00;
                        if (init_idx == 4'd13)
                            nx_state = S_IRST;
                        else
                            nx_idx = init_idx + 4'd1;
                    end else begin
                        do_addr = 1'b1;
                        a_reg   = init_idx;
                    end
                end
                S_IRST: begin
                    // A CPU address write in this same cycle still counts.
                    do_addr  = 1'b1;
                    a_reg    = nx_shadow;
                    nx_state = S_IDONE;
                end
                S_IDLE: begin
                    if (HOST_VALID)
                        nx_state = S_HOP;
                end
                S_HOP: begin
                    if (hit_host) begin
                        do_data  = 1'b1;
                        d_val    = HOST_DATA;
                        nx_ack   = 1'b1;
                        nx_state = S_HDONE;
                    end else begin
                        do_addr = 1'b1;
                        a_reg   = HOST_REG;
                    end
                end
                S_HDONE: begin
                    nx_state = HOST_VALID ? S_HOP : S_HRST;
                end
                S_HRST: begin
                    if (!hit_shadow) begin
                        do_addr = 1'b1;
                        a_reg   = shadow;
                    end
                    nx_state = S_IDLE;
                end
                default: ;
            endcase
        end

        if (do_addr) begin
            nx_bdir   = 1'b1;
            nx_bc     = 1'b1;
            nx_di     = {4'h0, a_reg};
            nx_addr   = a_reg;
            nx_avalid = 1'b1;
        end else if (do_data) begin
            nx_bdir = 1'b1;
            nx_di   = d_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= INIT_EN ? S_INIT : S_IDONE;
            init_idx  <= '0;
            shadow    <= '0;
            ay_addr   <= '0;
            ay_avalid <= 1'b0;
            cpu_pend  <= 1'b0;
            cpu_data  <= '0;
            HOST_ACK  <= 1'b0;
            INIT_DONE <= 1'b0;
            AY_BDIR   <= 1'b0;
            AY_BC     <= 1'b0;
            AY_DI     <= '0;
        end else begin
            state     <= nx_state;
            init_idx  <= nx_idx;
            shadow    <= nx_shadow;
            ay_addr   <= nx_addr;
            ay_avalid <= nx_avalid;
            cpu_pend  <= nx_pend;
            cpu_data  <= nx_pdata;
            HOST_ACK  <= nx_ack;
            INIT_DONE <= nx_done;
            AY_BDIR   <= nx_bdir;
            AY_BC     <= nx_bc;
            AY_DI     <= nx_di;
        end
    end

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// Testbench for ay_bus_sequencer: directed steps followed by randomized CPU
// and host writes predicted from the AY latch / shadow rules.
module tb_ay_bus_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       CPU_REQ;
    logic       CPU_SEL;
    logic [7:0] CPU_DI;
    logic       HOST_VALID;
    logic [3:0] HOST_REG;
    logic [7:0] HOST_DATA;
    logic       HOST_ACK;
    logic       INIT_DONE;
    logic       AY_BDIR;
    logic       AY_BC;
    logic [7:0] AY_DI;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference: what the AY address latch holds and the CPU's shadow register.
    logic [3:0] m_shadow;
    logic [3:0] m_addr;

    always #5 CLK = ~CLK;

    ay_bus_sequencer #(
        .INIT_EN    (1'b1),
        .INIT_MIXER (8'hFF)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .CPU_REQ    (CPU_REQ),
        .CPU_SEL    (CPU_SEL),
        .CPU_DI     (CPU_DI),
        .HOST_VALID (HOST_VALID),
        .HOST_REG   (HOST_REG),
        .HOST_DATA  (HOST_DATA),
        .HOST_ACK   (HOST_ACK),
        .INIT_DONE  (INIT_DONE),
        .AY_BDIR    (AY_BDIR),
        .AY_BC      (AY_BC),
        .AY_DI      (AY_DI)
    );

    // Word layout: {bdir, bc, di[7:0], ack, done}
    function automatic logic [11:0] w_addr(input logic [3:0] r, input logic done);
        return {1'b1, 1'b1, 4'h0, r, 1'b0, done};
    endfunction

    function automatic logic [11:0] w_data(input logic [7:0] d, input logic ack, input logic done);
        return {1'b1, 1'b0, d, ack, done};
    endfunction

    function automatic logic [11:0] w_idle(input logic done);
        return {1'b0, 1'b0, 8'h00, 1'b0, done};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {AY_BDIR, AY_BC, AY_DI, HOST_ACK, INIT_DONE};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed bdir/bc/di/ack/done=%b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                   tag, obs[11], obs[10], obs[9:2], obs[1], obs[0],
                   exp[11], exp[10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic wait_bus(input string tag);
        for (int i = 0; i < 20 && AY_BDIR !== 1'b1; i++)
            step();
        n_cmp++;
        assert (AY_BDIR === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: no bus cycle within bound, observed bdir=%b expected 1", tag, AY_BDIR);
        end
    endtask

    // Expects the init sequence starting with the currently visible cycle.
    task automatic check_init(input logic inject, input logic [3:0] restore);
        for (int k = 0; k < 14; k++) begin
            check($sformatf("init_addr_r%0d", k), w_addr(4'(k), 1'b0));
            if (inject && k == 3) begin
                CPU_REQ = 1'b1; CPU_SEL = 1'b1; CPU_DI = 8'h05;
            end
            if (inject && k == 8) begin
                CPU_REQ = 1'b1; CPU_SEL = 1'b0; CPU_DI = 8'hAA;
            end
            step();
            CPU_REQ = 1'b0;
            check($sformatf("init_data_r%0d", k), w_data((k == 7) ? 8'hFF : 8'h00, 1'b0, 1'b0));
            step();
        end
        check("init_restore", w_addr(restore, 1'b0));
        step();
        check("init_done", w_idle(1'b1));
    endtask

    task automatic host_write(input string tag, input logic [3:0] r, input logic [7:0] d);
        HOST_VALID = 1'b1; HOST_REG = r; HOST_DATA = d;
        wait_bus(tag);
        if (m_addr != r) begin
            check({tag, "_addr"}, w_addr(r, 1'b1));
            step();
        end
        check({tag, "_data"}, w_data(d, 1'b1, 1'b1));
        HOST_VALID = 1'b0;
        m_addr = r;
        step();
        check({tag, "_gap"}, w_idle(1'b1));
        step();
        if (m_addr != m_shadow) begin
            check({tag, "_restore"}, w_addr(m_shadow, 1'b1));
            m_addr = m_shadow;
        end else begin
            check({tag, "_norestore"}, w_idle(1'b1));
        end
        step();
        check({tag, "_after"}, w_idle(1'b1));
    endtask

    task automatic cpu_write(input string tag, input logic sel, input logic [7:0] d);
        CPU_REQ = 1'b1; CPU_SEL = sel; CPU_DI = d;
        step();
        CPU_REQ = 1'b0;
        if (sel) begin
            check({tag, "_addr"}, w_addr(d[3:0], 1'b1));
            m_shadow = d[3:0];
            m_addr   = d[3:0];
        end else begin
            if (m_addr != m_shadow) begin
                check({tag, "_addr"}, w_addr(m_shadow, 1'b1));
                m_addr = m_shadow;
                step();
            end
            check({tag, "_data"}, w_data(d, 1'b0, 1'b1));
        end
        step();
        check({tag, "_after"}, w_idle(1'b1));
        step();
        step();
        step();
    endtask

    initial begin
        RESET_N = 1'b0; CPU_REQ = 1'b0; CPU_SEL = 1'b0; CPU_DI = '0;
        HOST_VALID = 1'b0; HOST_REG = '0; HOST_DATA = '0;

        // 1: reset then init
        step();
        step();
        check("reset", w_idle(1'b0));
        RESET_N = 1'b1;
        step();
        check_init(1'b0, 4'h0);
        m_shadow = 4'h0; m_addr = 4'h0;

        // 2: CPU address then data, one cycle latency each
        step();
        CPU_REQ = 1'b1; CPU_SEL = 1'b1; CPU_DI = 8'h08;
        step();
        CPU_REQ = 1'b0;
        check("cpu_addr8", w_addr(4'h8, 1'b1));
        step();
        check("cpu_addr8_idle", w_idle(1'b1));
        step(); step(); step();
        CPU_REQ = 1'b1; CPU_SEL = 1'b0; CPU_DI = 8'h0F;
        step();
        CPU_REQ = 1'b0;
        check("cpu_data0f_direct", w_data(8'h0F, 1'b0, 1'b1));
        step();
        check("cpu_data0f_idle", w_idle(1'b1));
        m_shadow = 4'h8; m_addr = 4'h8;

        // 3: host write with restore
        HOST_VALID = 1'b1; HOST_REG = 4'd11; HOST_DATA = 8'h34;
        wait_bus("h3");
        check("h3_addr11", w_addr(4'd11, 1'b1));
        step();
        check("h3_data34", w_data(8'h34, 1'b1, 1'b1));
        HOST_VALID = 1'b0;
        step();
        check("h3_gap", w_idle(1'b1));
        step();
        check("h3_restore8", w_addr(4'h8, 1'b1));
        step();
        check("h3_idle", w_idle(1'b1));

        // 4: CPU preempts host between address and data
        step(); step();
        HOST_VALID = 1'b1; HOST_REG = 4'd11; HOST_DATA = 8'h34;
        wait_bus("h4");
        check("h4_k_addr11", w_addr(4'd11, 1'b1));
        CPU_REQ = 1'b1; CPU_SEL = 1'b0; CPU_DI = 8'h1F;
        step();
        CPU_REQ = 1'b0;
        check("h4_k1_addr8", w_addr(4'h8, 1'b1));
        step();
        check("h4_k2_data1f", w_data(8'h1F, 1'b0, 1'b1));
        step();
        check("h4_k3_addr11", w_addr(4'd11, 1'b1));
        step();
        check("h4_k4_data34", w_data(8'h34, 1'b1, 1'b1));
        HOST_VALID = 1'b0;
        step();
        check("h4_k5_gap", w_idle(1'b1));
        step();
        check("h4_k6_restore8", w_addr(4'h8, 1'b1));
        step();
        check("h4_idle", w_idle(1'b1));

        // 5: back-to-back host requests without restore between them
        step();
        HOST_VALID = 1'b1; HOST_REG = 4'd11; HOST_DATA = 8'h34;
        wait_bus("h5");
        check("h5_addr11", w_addr(4'd11, 1'b1));
        step();
        check("h5_data34", w_data(8'h34, 1'b1, 1'b1));
        HOST_REG = 4'd0; HOST_DATA = 8'h55;
        step();
        check("h5_gap", w_idle(1'b1));
        step();
        check("h5_addr0", w_addr(4'h0, 1'b1));
        step();
        check("h5_data55", w_data(8'h55, 1'b1, 1'b1));
        HOST_VALID = 1'b0;
        step();
        check("h5_gap2", w_idle(1'b1));
        step();
        check("h5_restore8", w_addr(4'h8, 1'b1));
        step();
        check("h5_idle", w_idle(1'b1));

        // 6: reset aborts a host write; init restarts, CPU writes during init
        step();
        HOST_VALID = 1'b1; HOST_REG = 4'd11; HOST_DATA = 8'h34;
        wait_bus("h6");
        check("h6_addr11", w_addr(4'd11, 1'b1));
        RESET_N = 1'b0;
        step();
        check("h6_reset_abort", w_idle(1'b0));
        HOST_VALID = 1'b0;
        step();
        check("h6_reset_hold", w_idle(1'b0));
        RESET_N = 1'b1;
        step();
        check_init(1'b1, 4'h5);
        m_shadow = 4'h5; m_addr = 4'h5;
        step();

        // Randomized CPU and host traffic
        for (int i = 0; i < 30; i++) begin
            int unsigned kind;
            logic [7:0] d;
            logic [3:0] r;
            kind = $urandom_range(0, 9);
            d = 8'($urandom);
            r = 4'($urandom_range(0, 15));
            if (kind < 3)
                cpu_write($sformatf("rnd%0d_cpuaddr", i), 1'b1, d);
            else if (kind < 6)
                cpu_write($sformatf("rnd%0d_cpudata", i), 1'b0, d);
            else
                host_write($sformatf("rnd%0d_host", i), r, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
